// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-Lite slave to APB3 master sequencer: one AHB transfer at a time, decoded
// onto NUM_SLV APB selects, with registered AHB response and APB outputs.
module ahb_apb_bridge_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NUM_SLV = 6,
  parameter int IDX_W   = 3,
  parameter int SLV_LSB = 12
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [AW-1:0]      HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [DW-1:0]      HWDATA,
  output logic [DW-1:0]      HRDATA,
  output logic               HREADY,
  output logic [1:0]         HRESP,
  output logic [AW-1:0]      PADDR,
  output logic [NUM_SLV-1:0] PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [DW-1:0]      PWDATA,
  input  logic [DW-1:0]      PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_e;

  state_e             state_q;
  logic [AW-1:0]      addr_q;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DW-1:0]      hrdata_q;
  logic               hready_q;
  logic [1:0]         hresp_q;
  logic [AW-1:0]      paddr_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q;
  logic               pwrite_q;
  logic [DW-1:0]      pwdata_q;

  logic [IDX_W-1:0]   idx;
  logic               xfer_vld;
  logic               dec_err;

  function automatic logic [NUM_SLV-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(NUM_SLV-1){1'b0}}, 1'b1} << i;
  endfunction

  // New address phases are only taken while the bus shows HREADY high,
  // i.e. in IDLE or in the second error cycle.
  assign idx      = HADDR[SLV_LSB +: IDX_W];
  assign xfer_vld = HSEL & HTRANS[1] & hready_q &
                    ((state_q == S_IDLE) | (state_q == S_ERR2));
  assign dec_err  = (int'(idx) >= NUM_SLV) | (HSIZE > 3'd2);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      hrdata_q  <= '0;
      hready_q  <= 1'b1;
      hresp_q   <= RESP_OKAY;
      paddr_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR2: begin
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= RESP_OKAY;
          if (xfer_vld) begin
            addr_q   <= HADDR;
            wr_q     <= HWRITE;
            idx_q    <= idx;
            hready_q <= 1'b0;
            if (dec_err) begin
              state_q <= S_ERR1;
              hresp_q <= RESP_ERR;
            end else if (HWRITE) begin
              state_q <= S_WDATA;
            end else begin
              // Reads skip the data-capture cycle and go straight to SETUP.
              state_q  <= S_SETUP;
              psel_q   <= onehot(idx);
              paddr_q  <= HADDR;
              pwrite_q <= 1'b0;
            end
          end
        end
        S_WDATA: begin
          state_q  <= S_SETUP;
          pwdata_q <= HWDATA;
          psel_q   <= onehot(idx_q);
          paddr_q  <= addr_q;
          pwrite_q <= 1'b1;
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
        end
        S_ACCESS: begin
          if (PREADY) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (PSLVERR) begin
              state_q <= S_ERR1;
              hresp_q <= RESP_ERR;
            end else begin
              state_q  <= S_IDLE;
              hready_q <= 1'b1;
              if (!wr_q) hrdata_q <= PRDATA;
            end
          end
        end
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= RESP_ERR;
        end
        default: begin
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= RESP_OKAY;
        end
      endcase
    end
  end

  assign HRDATA  = hrdata_q;
  assign HREADY  = hready_q;
  assign HRESP   = hresp_q;
  assign PADDR   = paddr_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;

endmodule
